// File: rtl/pio_osr.sv
// rtl/pio_osr.sv - PIO output shift register with TX FIFO refill, OUT extraction and stall reporting
// Optional MOV-to-OSR load port enabled by defining PIO_OSR_MOV_EN.
module pio_osr #(
  parameter bit RESET_EMPTY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_pull,
  input  logic        out_req,
  input  logic [4:0]  out_bits,
  input  logic        shift_right,
  input  logic        autopull_en,
  input  logic [4:0]  pull_thresh,
  input  logic        pull_req,
  input  logic        pull_block,
  input  logic        pull_ifempty,
  input  logic [31:0] x_in,
`ifdef PIO_OSR_MOV_EN
  input  logic        mov_load,
  input  logic [31:0] mov_data,
`endif
  output logic        stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [5:0]  shift_cnt
);

  logic [31:0] osr_q, osr_d;
  logic [5:0]  shift_cnt_q, shift_cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic        mov_load_i;
  logic [31:0] mov_data_i;

`ifdef PIO_OSR_MOV_EN
  assign mov_load_i = mov_load;
  assign mov_data_i = mov_data;
`else
  assign mov_load_i = 1'b0;
  assign mov_data_i = 32'd0;
`endif

  logic [5:0]  thr, n;
  logic        at_thr, ap_hit;
  logic [31:0] src, out_mask, shr_data, shr_osr, shl_data, shl_osr;
  logic [6:0]  cnt_sum;
  logic [5:0]  cnt_sat;

  assign thr    = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
  assign n      = (out_bits == 5'd0) ? 6'd32 : {1'b0, out_bits};
  assign at_thr = (shift_cnt_q >= thr);
  assign ap_hit = autopull_en && at_thr;

  // An autopulling OUT operates on the FIFO head directly, so the refill and shift share one cycle.
  assign src      = ap_hit ? fifo_dout : osr_q;
  assign out_mask = 32'hFFFF_FFFF >> (6'd32 - n);
  assign shr_data = src & out_mask;
  assign shr_osr  = src >> n;
  assign shl_data = src >> (6'd32 - n);
  assign shl_osr  = src << n;

  assign cnt_sum = ap_hit ? {1'b0, n} : ({1'b0, shift_cnt_q} + {1'b0, n});
  assign cnt_sat = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

  always_comb begin
    osr_d       = osr_q;
    shift_cnt_d = shift_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    fifo_pull   = 1'b0;
    stall       = 1'b0;
    if (reset) begin
      fifo_pull = 1'b0;
    end else if (mov_load_i) begin
      osr_d       = mov_data_i;
      shift_cnt_d = 6'd0;
    end else if (pull_req) begin
      if (!(pull_ifempty && autopull_en && !at_thr)) begin
        if (!fifo_empty) begin
          fifo_pull   = 1'b1;
          osr_d       = fifo_dout;
          shift_cnt_d = 6'd0;
        end else if (pull_block) begin
          stall = 1'b1;
        end else begin
          osr_d       = x_in;
          shift_cnt_d = 6'd0;
        end
      end
    end else if (out_req) begin
      if (ap_hit && fifo_empty) begin
        stall = 1'b1;
      end else begin
        fifo_pull   = ap_hit;
        osr_d       = shift_right ? shr_osr : shl_osr;
        out_data_d  = shift_right ? shr_data : shl_data;
        out_valid_d = 1'b1;
        shift_cnt_d = cnt_sat;
      end
    end else if (ap_hit && !fifo_empty) begin
      fifo_pull   = 1'b1;
      osr_d       = fifo_dout;
      shift_cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osr_q       <= 32'd0;
      shift_cnt_q <= RESET_EMPTY ? 6'd32 : 6'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      osr_q       <= osr_d;
      shift_cnt_q <= shift_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign shift_cnt = shift_cnt_q;

endmodule

// File: tb/tb_pio_osr.sv
// tb/tb_pio_osr.sv - randomized bench for pio_osr against a queue-based reference model
module tb_pio_osr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_pull;
  logic        out_req;
  logic [4:0]  out_bits;
  logic        shift_right;
  logic        autopull_en;
  logic [4:0]  pull_thresh;
  logic        pull_req;
  logic        pull_block;
  logic        pull_ifempty;
  logic [31:0] x_in;
  logic        stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  shift_cnt;

  pio_osr #(.RESET_EMPTY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
    .out_req(out_req), .out_bits(out_bits), .shift_right(shift_right),
    .autopull_en(autopull_en), .pull_thresh(pull_thresh),
    .pull_req(pull_req), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
    .x_in(x_in),
`ifdef PIO_OSR_MOV_EN
    .mov_load(1'b0), .mov_data(32'd0),
`endif
    .stall(stall), .out_data(out_data), .out_valid(out_valid), .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the TX FIFO contents and the architectural view of the OSR.
  logic [31:0] q[$];
  logic [31:0] m_osr;
  int          m_cnt;
  logic [31:0] m_out_data;
  logic        m_out_valid;
  logic        s_pull, s_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() == 0) ? $urandom : q[0];
  endtask

  task automatic model_reset();
    m_osr = 32'd0; m_cnt = 32; m_out_data = 32'd0; m_out_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    out_req = 0; pull_req = 0; out_bits = 0; shift_right = 1; autopull_en = 0;
    pull_thresh = 0; pull_block = 1; pull_ifempty = 0; x_in = 0;
  endtask

  // One clock: drive, predict and check combinational outputs, then check registered state.
  task automatic cycle();
    int thr, n, c;
    logic at, ap, emp, e_pull, e_stall, nv;
    logic [31:0] head;
    longint unsigned t;
    drive_fifo();
    #1;
    thr = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    n   = (out_bits == 0) ? 32 : int'(out_bits);
    at  = (m_cnt >= thr);
    ap  = autopull_en && at;
    emp = (q.size() == 0);
    head = emp ? 32'd0 : q[0];
    e_pull = 0; e_stall = 0; nv = 0;
    if (pull_req) begin
      if (!(pull_ifempty && autopull_en && !at)) begin
        if (!emp) begin e_pull = 1; m_osr = head; m_cnt = 0; end
        else if (pull_block) e_stall = 1;
        else begin m_osr = x_in; m_cnt = 0; end
      end
    end else if (out_req) begin
      if (ap && emp) e_stall = 1;
      else begin
        t = {32'd0, m_osr}; c = m_cnt;
        if (ap) begin e_pull = 1; t = {32'd0, head}; c = 0; end
        if (shift_right) begin
          m_out_data = 32'(t & ((64'd1 << n) - 64'd1));
          m_osr      = 32'(t >> n);
        end else begin
          t = t << n;
          m_out_data = 32'(t >> 32);
          m_osr      = 32'(t);
        end
        m_cnt = (c + n > 32) ? 32 : c + n;
        nv = 1;
      end
    end else if (ap && !emp) begin
      e_pull = 1; m_osr = head; m_cnt = 0;
    end
    m_out_valid = nv;
    check("fifo_pull", {31'd0, fifo_pull}, {31'd0, e_pull});
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    s_pull = fifo_pull; s_stall = stall;
    @(negedge clk);
    if (e_pull) q.delete(0);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
    check("out_data", out_data, m_out_data);
    check("shift_cnt", {26'd0, shift_cnt}, 32'(m_cnt));
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    pull_req = 1;
    drive_fifo();
    repeat (2) @(negedge clk);
    check("rst_cnt", {26'd0, shift_cnt}, 32'd32);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_pull", {31'd0, fifo_pull}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset = 0;
    idle_inputs();
    model_reset();

    q.push_back(32'hDEADBEEF);
    pull_req = 1;
    cycle();
    check("pull_pulse", {31'd0, s_pull}, 32'd1);
    check("pull_cnt", {26'd0, shift_cnt}, 32'd0);
    pull_req = 0; out_req = 1; out_bits = 8; shift_right = 1;
    cycle();
    check("pull_once", {31'd0, s_pull}, 32'd0);
    check("out8r_data", out_data, 32'hEF);
    check("out8r_cnt", {26'd0, shift_cnt}, 32'd8);

    q.push_back(32'hDEADBEEF);
    out_req = 0; pull_req = 1;
    cycle();
    pull_req = 0; out_req = 1; out_bits = 4; shift_right = 0;
    cycle();
    check("out4l_a", out_data, 32'hD);
    cycle();
    check("out4l_b", out_data, 32'hE);
    check("out4l_cnt", {26'd0, shift_cnt}, 32'd8);
    out_bits = 0;
    cycle();
    check("out32_sat", {26'd0, shift_cnt}, 32'd32);

    out_req = 0; pull_req = 1; pull_block = 0; x_in = 32'hA5A5A5A5;
    cycle();
    check("noblk_stall", {31'd0, s_stall}, 32'd0);
    check("noblk_cnt", {26'd0, shift_cnt}, 32'd0);
    pull_req = 0; out_req = 1; out_bits = 0; shift_right = 1;
    cycle();
    check("noblk_osr", out_data, 32'hA5A5A5A5);

    out_req = 0; pull_req = 1; x_in = 32'h0000BEEF;
    cycle();
    pull_req = 0; out_req = 1; out_bits = 16; autopull_en = 1; pull_thresh = 16;
    cycle();
    check("ap_first", out_data, 32'hBEEF);
    repeat (3) begin
      cycle();
      check("ap_stall", {31'd0, s_stall}, 32'd1);
    end
    q.push_back(32'h12345678);
    cycle();
    check("ap_pull", {31'd0, s_pull}, 32'd1);
    check("ap_data", out_data, 32'h5678);
    check("ap_cnt", {26'd0, shift_cnt}, 32'd16);

    out_req = 0; autopull_en = 0; pull_req = 1; pull_block = 1;
    repeat (5) begin
      cycle();
      check("blk_stall", {31'd0, s_stall}, 32'd1);
    end
    q.push_back(32'hCAFEF00D);
    cycle();
    check("blk_release", {31'd0, s_stall}, 32'd0);
    check("blk_pull", {31'd0, s_pull}, 32'd1);

    pull_req = 0; out_req = 1; out_bits = 0;
    cycle();
    out_req = 0; autopull_en = 1; pull_thresh = 0;
    q.push_back(32'h0BADC0DE);
    cycle();
    check("bg_pull", {31'd0, s_pull}, 32'd1);
    check("bg_cnt", {26'd0, shift_cnt}, 32'd0);
    cycle();
    check("bg_once", {31'd0, s_pull}, 32'd0);

    out_req = 1; out_bits = 4;
    cycle();
    q.push_back(32'h77778888);
    out_req = 0; pull_req = 1; pull_ifempty = 1;
    cycle();
    check("ifempty_pull", {31'd0, s_pull}, 32'd0);
    check("ifempty_cnt", {26'd0, shift_cnt}, 32'd4);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      out_req      = (r <= 3) || (r == 6);
      pull_req     = (r == 4) || (r == 5) || (r == 6);
      out_bits     = 5'($urandom);
      shift_right  = 1'($urandom);
      autopull_en  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 4))
        0: pull_thresh = 0;
        1: pull_thresh = 4;
        2: pull_thresh = 8;
        3: pull_thresh = 16;
        default: pull_thresh = 5'($urandom);
      endcase
      pull_block   = ($urandom_range(0, 3) != 0);
      pull_ifempty = 1'($urandom);
      x_in         = $urandom;
      if (q.size() < 4 && $urandom_range(0, 2) == 0) q.push_back($urandom);
      cycle();
    end

    idle_inputs();
    q.delete();
    pull_req = 1; pull_block = 1;
    drive_fifo();
    #1;
    check("mid_stall", {31'd0, stall}, 32'd1);
    reset = 1;
    #1;
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_pull", {31'd0, fifo_pull}, 32'd0);
    check("arst_cnt", {26'd0, shift_cnt}, 32'd32);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    pull_req = 0;
    q.push_back(32'h13579BDF);
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (3) begin
      cycle();
      check("post_rst_pull", {31'd0, s_pull}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
